// File: rtl/uart_rx_frame_pkg.sv
// Shared definitions for the 8N1 UART receiver: FSM states, oversampling
// constants, the three-sample majority vote and the prescaler divisor.
package uart_rx_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  localparam int         OVERSAMPLE   = 16;
  localparam logic [3:0] SAMPLE_FIRST = 4'd7;
  localparam logic [3:0] SAMPLE_MID   = 4'd8;
  localparam logic [3:0] SAMPLE_LAST  = 4'd9;
  localparam logic [3:0] TICK_LAST    = 4'(OVERSAMPLE - 1);

  // Bit value decided by two of three samples taken around mid-bit.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Core clocks per 1/16 bit.
  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Oversampling prescaler: pulses tick once every DIV clocks while run is high.
// Held at zero while run is low, so the first tick after run rises lands
// exactly DIV clocks later and the sampling phase follows the start edge.
module uart_rx_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == CNT_LAST);

  // Divider counter: cleared while stopped, wraps after each tick.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver with 16x oversampling, start-bit validation, majority
// sampling, framing/overrun/break flags and a ready/ack byte handshake.
module uart_rx_frame
  import uart_rx_frame_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115_200,
  parameter int DIV    = calc_div(CLK_HZ, BAUD)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  input  logic       rx_ack,
  output logic       rx_ferr,
  output logic       rx_ovr,
  output logic       rx_break
);

  rx_state_t  state, next_state;
  logic       rxd_meta, rxd_s;
  logic       tick_run, tick;
  logic [3:0] tick_cnt;
  logic [2:0] bit_cnt;
  logic [1:0] samples;
  logic [7:0] shift_reg;
  logic       bit_val;
  logic       sample_end, bit_end;
  logic       shift_en, bit_adv, deliver;

  // Two-flop synchronizer; resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  assign tick_run = (state != ST_IDLE);

  uart_rx_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (tick_run),
    .tick (tick)
  );

  assign sample_end = tick && (tick_cnt == SAMPLE_LAST);
  assign bit_end    = tick && (tick_cnt == TICK_LAST);
  // Third vote is the live sample taken on the deciding tick itself.
  assign bit_val    = majority3(samples[0], samples[1], rxd_s);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic: frame sequencing, glitch rejection and break detection.
  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    next_state = state;
    case (state)
      ST_IDLE:  if (!rxd_s) next_state = ST_START;
      ST_START: begin
        if (sample_end && bit_val) next_state = ST_IDLE;
        else if (bit_end)          next_state = ST_DATA;
      end
      ST_DATA:  if (bit_end && (bit_cnt == 3'd7)) next_state = ST_STOP;
      ST_STOP:  begin
        // Low stop bit with an all-zero byte means the line is held low: break.
        if (sample_end) next_state = (!bit_val && (shift_reg == 8'h00)) ? ST_BREAK : ST_IDLE;
      end
      ST_BREAK: if (rxd_s) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Output/control decode from the current state.
  always_comb begin
    shift_en = 1'b0;
    bit_adv  = 1'b0;
    deliver  = 1'b0;
    rx_break = 1'b0;
    case (state)
      ST_DATA: begin
        shift_en = sample_end;
        bit_adv  = bit_end;
      end
      ST_STOP:  deliver  = sample_end;
      ST_BREAK: rx_break = 1'b1;
      default: ;
    endcase
  end

  // Tick-within-bit and bit counters plus the first two majority samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      samples  <= '0;
    end else if (state == ST_IDLE) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else if (tick) begin
      tick_cnt <= tick_cnt + 4'd1;
      if (tick_cnt == SAMPLE_FIRST) samples[0] <= rxd_s;
      if (tick_cnt == SAMPLE_MID)   samples[1] <= rxd_s;
      if (bit_adv)                  bit_cnt    <= bit_cnt + 3'd1;
    end
  end

  // Receive shift register, LSB arrives first so shift right.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        shift_reg <= '0;
    else if (shift_en) shift_reg <= {bit_val, shift_reg[7:1]};
  end

  // Output byte and handshake flags; a delivery outranks a same-cycle ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data  <= '0;
      rx_ready <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_ovr   <= 1'b0;
    end else if (deliver) begin
      rx_data  <= shift_reg;
      rx_ferr  <= ~bit_val;
      rx_ready <= 1'b1;
      rx_ovr   <= rx_ready & ~rx_ack;
    end else if (rx_ack) begin
      rx_ready <= 1'b0;
      rx_ovr   <= 1'b0;
    end
  end

endmodule
